// File: rtl/hazard_pipe_regs_pkg.sv
// Shared constants and types for the fetch/decode/execute pipeline registers.
// Imported by the hazard_pipe_regs slice and its bench.
package pipe_pkg;

   localparam int CTRL_BITS = 12;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMWRITE = 1;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_JUMP     = 3;

   typedef logic [CTRL_BITS-1:0] ctrl_t;

endpackage

// File: rtl/hazard_pipe_regs_if.sv
// Stall/flush bundle driven by the hazard unit.
// Consumed by the pipeline registers.
interface hazard_pipe_regs_if;

   logic StallF;
   logic StallD;
   logic FlushD;
   logic FlushE;

   modport master (
      output StallF, StallD, FlushD, FlushE
   );

   modport slave (
      input StallF, StallD, FlushD, FlushE
   );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register with clear-over-enable.
// Reset and clear both load CLR_VAL.
module pipe_stage_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= CLR_VAL;
      end else if (clr) begin
         q <= CLR_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID and ID/EX registers under hazard-unit stall/flush control,
// plus saturating hazard event counters.
module hazard_pipe_regs
   import pipe_pkg::*;
#(
   parameter int               DATA_W   = 32,
   parameter int               CTRL_W   = 12,
   parameter int               REG_AW   = 5,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int               CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   hazard_pipe_regs_if.slave hz,
   input  logic [DATA_W-1:0] PCNextF,
   input  logic [31:0]       InstrF,
   input  logic [DATA_W-1:0] PCPlus4F,
   input  logic [CTRL_W-1:0] CtrlD,
   input  logic [DATA_W-1:0] RD1D,
   input  logic [DATA_W-1:0] RD2D,
   input  logic [DATA_W-1:0] ImmExtD,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] RdD,
   input  logic              cnt_clr,
   output logic [DATA_W-1:0] PCF,
   output logic [31:0]       InstrD,
   output logic [DATA_W-1:0] PCD,
   output logic [DATA_W-1:0] PCPlus4D,
   output logic              ValidD,
   output logic [CTRL_W-1:0] CtrlE,
   output logic [DATA_W-1:0] RD1E,
   output logic [DATA_W-1:0] RD2E,
   output logic [DATA_W-1:0] ImmExtE,
   output logic [DATA_W-1:0] PCE,
   output logic [DATA_W-1:0] PCPlus4E,
   output logic [REG_AW-1:0] Rs1E,
   output logic [REG_AW-1:0] Rs2E,
   output logic [REG_AW-1:0] RdE,
   output logic              ValidE,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam int FD_W = 1 + 32 + 2 * DATA_W;
   localparam int DE_W = 1 + CTRL_W + 5 * DATA_W + 3 * REG_AW;

   // A flushed IF/ID slot must decode as a harmless addi x0,x0,0
   localparam logic [FD_W-1:0] FD_CLR =
      {1'b0, NOP_INSTR, {(2 * DATA_W){1'b0}}};

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [FD_W-1:0] fdD;
   logic [FD_W-1:0] fdQ;
   logic [DE_W-1:0] deD;
   logic [DE_W-1:0] deQ;
   logic            stallEv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PCF <= RESET_PC;
      end else if (!hz.StallF) begin
         PCF <= PCNextF;
      end
   end

   assign fdD = {1'b1, InstrF, PCF, PCPlus4F};

   pipe_stage_reg #(
      .WIDTH   (FD_W),
      .CLR_VAL (FD_CLR)
   ) uFd (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!hz.StallD),
      .clr   (hz.FlushD),
      .d     (fdD),
      .q     (fdQ)
   );

   assign {ValidD, InstrD, PCD, PCPlus4D} = fdQ;

   assign deD = {ValidD, CtrlD, RD1D, RD2D, ImmExtD,
                 PCD, PCPlus4D, Rs1D, Rs2D, RdD};

   // An all-zero bubble has RegWrite=0 and rd=x0, so it never forwards
   pipe_stage_reg #(
      .WIDTH   (DE_W),
      .CLR_VAL ('0)
   ) uDe (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .clr   (hz.FlushE),
      .d     (deD),
      .q     (deQ)
   );

   assign {ValidE, CtrlE, RD1E, RD2E, ImmExtE,
           PCE, PCPlus4E, Rs1E, Rs2E, RdE} = deQ;

   assign stallEv = hz.StallD && !hz.FlushD;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (stallEv && stall_cnt != CNT_MAX) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         flush_cnt <= '0;
      end else if (hz.FlushD && flush_cnt != CNT_MAX) begin
         flush_cnt <= flush_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (cnt_clr) begin
         bubble_cnt <= '0;
      end else if (hz.FlushE && bubble_cnt != CNT_MAX) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Table-driven bench with scoreboard queue for hazard_pipe_regs.
// Built with CNT_W=4 so counter saturation is reachable quickly.
module tb_hazard_pipe_regs;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam logic [11:0] CTRL = 12'h0A5;

   typedef struct {
      logic        sF, sD, fD, fE;
      logic [31:0] pcNext, instr;
      logic [31:0] expPcf, expInstrD, expPcD;
      logic        expVD, expVE, expLd;
      logic [3:0]  expSt, expFl, expBu;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [DW-1:0] PCNextF, PCPlus4F, RD1D, RD2D, ImmExtD;
   logic [31:0] InstrF;
   ctrl_t CtrlD;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic cnt_clr;
   logic [DW-1:0] PCF, PCD, PCPlus4D;
   logic [31:0] InstrD;
   logic ValidD, ValidE;
   ctrl_t CtrlE;
   logic [DW-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0] Rs1E, Rs2E, RdE;
   logic [CW-1:0] stall_cnt, flush_cnt, bubble_cnt;

   hazard_pipe_regs_if hz ();

   hazard_pipe_regs #(
      .DATA_W (DW), .CTRL_W (12), .REG_AW (5),
      .RESET_PC (32'h0), .CNT_W (CW)
   ) dut (
      .clk (clk), .rst_n (rst_n), .hz (hz.slave),
      .PCNextF (PCNextF), .InstrF (InstrF), .PCPlus4F (PCPlus4F),
      .CtrlD (CtrlD), .RD1D (RD1D), .RD2D (RD2D), .ImmExtD (ImmExtD),
      .Rs1D (Rs1D), .Rs2D (Rs2D), .RdD (RdD), .cnt_clr (cnt_clr),
      .PCF (PCF), .InstrD (InstrD), .PCD (PCD), .PCPlus4D (PCPlus4D),
      .ValidD (ValidD), .CtrlE (CtrlE), .RD1E (RD1E), .RD2E (RD2E),
      .ImmExtE (ImmExtE), .PCE (PCE), .PCPlus4E (PCPlus4E),
      .Rs1E (Rs1E), .Rs2E (Rs2E), .RdE (RdE), .ValidE (ValidE),
      .stall_cnt (stall_cnt), .flush_cnt (flush_cnt),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   int nVec = 0;
   int nFail = 0;
   vec_t tbl[10];
   vec_t sb[$];
   logic [3:0] cntQ[$];
   logic [31:0] curPc;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic sF, sD, fD, fE,
      input logic [31:0] pcNext, instr, expPcf, expInstrD, expPcD,
      input logic expVD, expVE, expLd,
      input logic [3:0] st, fl, bu);
      vec_t v;
      v.sF = sF; v.sD = sD; v.fD = fD; v.fE = fE;
      v.pcNext = pcNext; v.instr = instr;
      v.expPcf = expPcf; v.expInstrD = expInstrD; v.expPcD = expPcD;
      v.expVD = expVD; v.expVE = expVE; v.expLd = expLd;
      v.expSt = st; v.expFl = fl; v.expBu = bu;
      return v;
   endfunction

   task automatic drive(input logic sF, sD, fD, fE, cc,
                        input logic [31:0] pcNext, instr);
      hz.StallF = sF; hz.StallD = sD;
      hz.FlushD = fD; hz.FlushE = fE;
      cnt_clr = cc;
      PCNextF = pcNext; InstrF = instr;
      PCPlus4F = curPc + 32'd4;
      CtrlD = CTRL; RdD = 5'd1; Rs1D = 5'd2; Rs2D = 5'd3;
      RD1D = 32'h1111; RD2D = 32'h2222; ImmExtD = 32'h33;
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      drive(v.sF, v.sD, v.fD, v.fE, 1'b0, v.pcNext, v.instr);
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("PCF", PCF, e.expPcf);
      chk("InstrD", InstrD, e.expInstrD);
      chk("PCD", PCD, e.expPcD);
      chk("ValidD", 32'(ValidD), 32'(e.expVD));
      chk("ValidE", 32'(ValidE), 32'(e.expVE));
      chk("CtrlE", 32'(CtrlE), e.expLd ? 32'(CTRL) : 32'd0);
      chk("RdE", 32'(RdE), e.expLd ? 32'd1 : 32'd0);
      chk("stall_cnt", 32'(stall_cnt), 32'(e.expSt));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.expFl));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(e.expBu));
      curPc = e.expPcf;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] i0, i1, i2, i3, i4, i5, i6, nop;
      logic [3:0] stExp;
      i0 = 32'h00500093; i1 = 32'h00100113; i2 = 32'h00200193;
      i3 = 32'h00300213; i4 = 32'h00400293; i5 = 32'h00600313;
      i6 = 32'h00700393; nop = NOP_INSTR;
      //          sF sD fD fE pcNext  instr  pcf    instrD pcD  vD vE ld st fl bu
      tbl[0] = mk(0, 0, 0, 0, 32'h04, i0, 32'h04, i0,  32'h00, 1, 0, 1, 0, 0, 0);
      tbl[1] = mk(0, 0, 0, 0, 32'h08, i1, 32'h08, i1,  32'h04, 1, 1, 1, 0, 0, 0);
      tbl[2] = mk(0, 0, 0, 0, 32'h0C, i2, 32'h0C, i2,  32'h08, 1, 1, 1, 0, 0, 0);
      tbl[3] = mk(1, 1, 0, 1, 32'h10, i3, 32'h0C, i2,  32'h08, 1, 0, 0, 1, 0, 1);
      tbl[4] = mk(0, 0, 0, 0, 32'h10, i3, 32'h10, i3,  32'h0C, 1, 1, 1, 1, 0, 1);
      tbl[5] = mk(0, 0, 1, 1, 32'h40, i4, 32'h40, nop, 32'h00, 0, 0, 0, 1, 1, 2);
      tbl[6] = mk(0, 0, 0, 0, 32'h44, i5, 32'h44, i5,  32'h40, 1, 0, 1, 1, 1, 2);
      tbl[7] = mk(1, 1, 1, 0, 32'h48, i6, 32'h44, nop, 32'h00, 0, 1, 1, 1, 2, 2);
      tbl[8] = mk(1, 0, 1, 0, 32'h48, i6, 32'h44, nop, 32'h00, 0, 0, 1, 1, 3, 2);
      tbl[9] = mk(0, 0, 0, 0, 32'h48, i6, 32'h48, i6,  32'h44, 1, 0, 1, 1, 3, 2);

      curPc = 32'h0;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
      #12;
      chk("rst PCF", PCF, 32'h0);
      chk("rst InstrD", InstrD, nop);
      chk("rst ValidD", 32'(ValidD), 32'd0);
      chk("rst ValidE", 32'(ValidE), 32'd0);
      chk("rst CtrlE", 32'(CtrlE), 32'd0);
      chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 10; k++) step(tbl[k]);

      // Long stall run: counter must stop at all-ones
      stExp = 4'd1;
      for (int k = 0; k < 20; k++) begin
         drive(1, 1, 0, 0, 0, 32'h200, i0);
         stExp = (stExp == 4'hF) ? 4'hF : stExp + 4'd1;
         cntQ.push_back(stExp);
         @(posedge clk);
         #1;
         chk("sat stall_cnt", 32'(stall_cnt), 32'(cntQ.pop_front()));
         @(negedge clk);
      end
      chk("sat PCF hold", PCF, 32'h48);
      chk("sat flush_cnt", 32'(flush_cnt), 32'd3);
      chk("sat bubble_cnt", 32'(bubble_cnt), 32'd2);

      drive(1, 1, 0, 0, 1, 32'h200, i0);
      @(posedge clk);
      #1;
      chk("clr stall_cnt", 32'(stall_cnt), 32'd0);
      chk("clr flush_cnt", 32'(flush_cnt), 32'd0);
      chk("clr bubble_cnt", 32'(bubble_cnt), 32'd0);
      @(negedge clk);
      drive(1, 1, 0, 0, 0, 32'h200, i0);
      @(posedge clk);
      #1;
      chk("post-clr stall_cnt", 32'(stall_cnt), 32'd1);
      @(negedge clk);

      drive(0, 0, 0, 0, 0, 32'h100, i1);
      @(posedge clk);
      @(negedge clk);
      curPc = 32'h100;
      drive(0, 0, 0, 0, 0, 32'h104, i2);
      @(posedge clk);
      #1;
      chk("pre-rst PCF", PCF, 32'h104);
      chk("pre-rst ValidD", 32'(ValidD), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async PCF", PCF, 32'h0);
      chk("async InstrD", InstrD, nop);
      chk("async ValidD", 32'(ValidD), 32'd0);
      chk("async ValidE", 32'(ValidE), 32'd0);
      chk("async CtrlE", 32'(CtrlE), 32'd0);
      chk("async RdE", 32'(RdE), 32'd0);
      chk("async stall_cnt", 32'(stall_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
